// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared types and source IDs for the interrupt gateway.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } gw_state_e;

    // ID 0 is reserved by the PLIC to mean "no interrupt"
    localparam int IRQ_ID_NONE  = 0;
    localparam int IRQ_ID_AES   = 1;
    localparam int IRQ_ID_DMA   = 2;
    localparam int IRQ_ID_SPARE = 3;

endpackage
`default_nettype wire

// File: rtl/irq_gateway_src.sv
`default_nettype none
// ============================================================================
// Module      : irq_gateway_src
// Description : One interrupt source: synchroniser, rising-edge detect,
//               saturating edge counter and IDLE/PENDING/CLAIMED FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_gateway_src
    import irq_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic claim_i,
    input  logic complete_i,
    input  logic ovf_clr_i,
    output logic pending_o,
    output logic claimed_o,
    output logic ovf_o
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    gw_state_e        r_state;
    logic             r_pending;
    logic             r_claimed;
    logic             r_s_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic w_s;
    logic w_rise;
    logic w_inc;
    logic w_dec;
    logic w_sat;
    logic w_req;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Shift the raw line through the synchroniser chain
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= src_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_rise = w_s & ~r_s_prev;

    // A queued edge is consumed whenever an edge-mode source sits in IDLE
    assign w_dec = edge_mode_i && (r_state == IDLE) && (r_cnt != c_CNT_ZERO);

    // A new edge is banked when it cannot itself become the next request
    assign w_inc = edge_mode_i && w_rise && ((r_state != IDLE) || (r_cnt != c_CNT_ZERO));

    // Simultaneous consume+bank nets out, so overflow only on a pure increment
    assign w_sat = w_inc && !w_dec && (r_cnt == c_CNT_MAX);

    assign w_req = edge_mode_i ? (w_rise || (r_cnt != c_CNT_ZERO)) : w_s;

    // Edge history, banked-edge counter and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s_prev <= 1'b0;
            r_cnt    <= c_CNT_ZERO;
            r_ovf    <= 1'b0;
        end else begin
            r_s_prev <= w_s;
            if (!edge_mode_i) begin
                r_cnt <= c_CNT_ZERO;
            end else if (w_inc && !w_dec && !w_sat) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            if (w_sat) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Request lifecycle with registered pending/claimed outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_claimed <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state   <= PENDING;
                        r_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (claim_i) begin
                        r_state   <= CLAIMED;
                        r_pending <= 1'b0;
                        r_claimed <= 1'b1;
                    end
                end
                CLAIMED: begin
                    if (complete_i) begin
                        r_state   <= IDLE;
                        r_claimed <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                    r_claimed <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o = r_pending;
    assign claimed_o = r_claimed;
    assign ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/irq_gateway.sv
`default_nettype none
// ============================================================================
// Module      : irq_gateway
// Description : Per-source interrupt gateway in front of the PLIC pending
//               inputs; decodes claim/complete IDs to per-source strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_gateway
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 3,
    parameter int ID_W        = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] edge_mode_i,
    input  logic               claim_valid_i,
    input  logic [ID_W-1:0]    claim_id_i,
    input  logic               complete_valid_i,
    input  logic [ID_W-1:0]    complete_id_i,
    input  logic [NUM_SRC-1:0] ovf_clr_i,
    output logic [NUM_SRC:0]   pending_o,
    output logic [NUM_SRC:0]   claimed_o,
    output logic [NUM_SRC-1:0] ovf_o
);

    logic [NUM_SRC-1:0] w_claim;
    logic [NUM_SRC-1:0] w_complete;
    logic [NUM_SRC-1:0] w_pending;
    logic [NUM_SRC-1:0] w_claimed;

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            // Source k+1 responds only to its own ID; 0 and out-of-range IDs match nothing
            assign w_claim[k]    = claim_valid_i    && (claim_id_i    == ID_W'(k + 1));
            assign w_complete[k] = complete_valid_i && (complete_id_i == ID_W'(k + 1));

            irq_gateway_src #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_src (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .src_i       (src_i[k]),
                .edge_mode_i (edge_mode_i[k]),
                .claim_i     (w_claim[k]),
                .complete_i  (w_complete[k]),
                .ovf_clr_i   (ovf_clr_i[k]),
                .pending_o   (w_pending[k]),
                .claimed_o   (w_claimed[k]),
                .ovf_o       (ovf_o[k])
            );
        end
    endgenerate

    // Bit IRQ_ID_NONE is never requested
    assign pending_o = {w_pending, 1'b0};
    assign claimed_o = {w_claimed, 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_irq_gateway.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_gateway
// Description : Randomised scoreboard bench for irq_gateway with a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_gateway;

    localparam int NS      = 3;
    localparam int IDW     = 4;
    localparam int CW      = 3;
    localparam int SYNC    = 2;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int NCYC    = 4000;

    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_CLM  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NS-1:0]  src;
    logic [NS-1:0]  edge_mode;
    logic           claim_valid;
    logic [IDW-1:0] claim_id;
    logic           complete_valid;
    logic [IDW-1:0] complete_id;
    logic [NS-1:0]  ovf_clr;
    logic [NS:0]    pending;
    logic [NS:0]    claimed;
    logic [NS-1:0]  ovf;

    irq_gateway #(
        .NUM_SRC     (NS),
        .ID_W        (IDW),
        .CNT_W       (CW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .src_i            (src),
        .edge_mode_i      (edge_mode),
        .claim_valid_i    (claim_valid),
        .claim_id_i       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
        .ovf_clr_i        (ovf_clr),
        .pending_o        (pending),
        .claimed_o        (claimed),
        .ovf_o            (ovf)
    );

    typedef struct packed {
        logic [NS:0]   pend;
        logic [NS:0]   clm;
        logic [NS-1:0] ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: request state, banked-edge count and overflow per
    // source, plus the history of sampled inputs (hist[i] = input taken i+1
    // edges ago) from which the synchronised level and edge are read.
    int            m_st   [NS];
    int            m_cnt  [NS];
    bit            m_ovf  [NS];
    logic [NS-1:0] hist   [SYNC+1];

    function automatic void model_reset();
        for (int k = 0; k < NS; k++) begin
            m_st[k]  = M_IDLE;
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
        end
        for (int i = 0; i <= SYNC; i++) hist[i] = '0;
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < NS; k++) begin
            bit s, r, em, cl, cp, setovf;
            int inc, dec, n;
            s  = hist[SYNC-1][k];
            r  = s && !hist[SYNC][k];
            em = edge_mode[k];
            cl = claim_valid    && (int'(claim_id)    == k + 1);
            cp = complete_valid && (int'(complete_id) == k + 1);
            inc = 0; dec = 0; setovf = 1'b0;
            if (m_st[k] == M_IDLE) begin
                if (em) begin
                    if (m_cnt[k] > 0) begin
                        m_st[k] = M_PEND;
                        dec = 1;
                        inc = r ? 1 : 0;
                    end else if (r) begin
                        m_st[k] = M_PEND;
                    end
                end else if (s) begin
                    m_st[k] = M_PEND;
                end
            end else begin
                inc = (em && r) ? 1 : 0;
                if (m_st[k] == M_PEND && cl) m_st[k] = M_CLM;
                else if (m_st[k] == M_CLM && cp) m_st[k] = M_IDLE;
            end
            if (!em) begin
                m_cnt[k] = 0;
            end else begin
                n = m_cnt[k] + inc - dec;
                if (n > CNT_MAX) begin
                    n = CNT_MAX;
                    setovf = 1'b1;
                end
                m_cnt[k] = n;
            end
            if (setovf) m_ovf[k] = 1'b1;
            else if (ovf_clr[k]) m_ovf[k] = 1'b0;
        end
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = src;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        for (int k = 0; k < NS; k++) begin
            e.pend[k+1] = (m_st[k] == M_PEND);
            e.clm[k+1]  = (m_st[k] == M_CLM);
            e.ovf[k]    = m_ovf[k];
        end
        return e;
    endfunction

    // Monitor: compare registered outputs mid-cycle against the oldest expectation
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                total++;
                if (pending !== mon_e.pend) begin
                    bad++;
                    $display("FAIL pending t=%0t got=%b exp=%b", $time, pending, mon_e.pend);
                end
                total++;
                if (claimed !== mon_e.clm) begin
                    bad++;
                    $display("FAIL claimed t=%0t got=%b exp=%b", $time, claimed, mon_e.clm);
                end
                total++;
                if (ovf !== mon_e.ovf) begin
                    bad++;
                    $display("FAIL ovf t=%0t got=%b exp=%b", $time, ovf, mon_e.ovf);
                end
            end
        end
    end

    // Stimulus: three phases (busy strobes, rare strobes to saturate, mixed modes)
    initial begin
        int strobe_pct;
        rst            = 1'b1;
        src            = '0;
        edge_mode      = '0;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        ovf_clr        = '0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc < 1500)      strobe_pct = 40;
            else if (cyc < 2500) strobe_pct = 5;
            else                 strobe_pct = 30;

            if (cyc == 0)    edge_mode = 3'b010;
            if (cyc == 1500) edge_mode = 3'b111;
            if (cyc >= 2500 && $urandom_range(0, 99) == 0)
                edge_mode[$urandom_range(0, NS-1)] ^= 1'b1;

            rst = (cyc < 3) || ($urandom_range(0, 399) == 0);
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 3) == 0) src[k] = ~src[k];
                ovf_clr[k] = ($urandom_range(0, 19) == 0);
            end
            claim_valid    = ($urandom_range(0, 99) < strobe_pct);
            claim_id       = IDW'($urandom_range(0, 6));
            complete_valid = ($urandom_range(0, 99) < strobe_pct);
            complete_id    = IDW'($urandom_range(0, 6));

            if (rst) model_reset();
            else     model_edge();

            @(posedge clk);
            #1;
            sb.push_back(model_out());
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
